// File: rtl/cpu_pkg.sv
// cpu_pkg: shared operand-select encodings and constants for the ALU
// operand stage.
package cpu_pkg;

    // Operand A source select. Encoding 3 is reserved and decodes as zero.
    typedef enum logic [1:0] {
        SRC_A_REG  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } src_a_e;

    // Operand B source select.
    typedef enum logic [1:0] {
        SRC_B_REG  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2,
        SRC_B_ZERO = 2'd3
    } src_b_e;

    // Instruction-size constant used for return-address computation.
    // Zero-extended to the datapath width at the point of use.
    localparam int unsigned CONST_FOUR = 4;

endpackage : cpu_pkg

// File: rtl/imm_extend.sv
// imm_extend: combinational sign/zero extension of a raw immediate to the
// datapath width. When IMM_W equals WIDTH the immediate passes unchanged.
module imm_extend #(
    parameter int IMM_W = 16,
    parameter int WIDTH = 32
) (
    input  logic [IMM_W-1:0] imm,
    input  logic             imm_signed,
    output logic [WIDTH-1:0] imm_ext
);

    generate
        if (IMM_W < 1 || IMM_W > WIDTH) begin : g_bad_width
            $error("imm_extend: IMM_W must be in 1..WIDTH");
        end

        if (IMM_W == WIDTH) begin : g_pass
            // Full-width immediate: nothing to extend.
            assign imm_ext = imm;
            logic unused_sign;
            assign unused_sign = imm_signed;
        end else begin : g_extend
            // Replicate the top immediate bit only for signed immediates.
            logic fill_bit;
            assign fill_bit = imm_signed & imm[IMM_W-1];
            assign imm_ext  = {{(WIDTH-IMM_W){fill_bit}}, imm};
        end
    endgenerate

endmodule : imm_extend

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: one registered pipeline slot that selects and holds the
// two ALU operands.
//
// Handshake: a word moves in on a rising CLK edge when IN_VALID && IN_READY,
// and moves out when OUT_VALID && OUT_READY. IN_READY is the combinational
// (!OUT_VALID || OUT_READY), so a full slot accepts a new word in the same
// cycle it is drained. Once OUT_VALID is high, OP_A/OP_B stay stable until
// the word is taken. FLUSH drops the held word (OUT_VALID clears) and wins
// over a simultaneous load; the operand registers keep their old contents.
//
// Optional feature: define ALU_OPERAND_FORWARD_EN to bypass FWD_DATA in place
// of REG_A/REG_B when the forwarded destination matches a nonzero source
// index. Without it the FWD_* ports are present but ignored.
module alu_operand_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] REG_A,
    input  logic [WIDTH-1:0] REG_B,
    input  logic [IDX_W-1:0] RS_A,
    input  logic [IDX_W-1:0] RS_B,
    input  logic [IMM_W-1:0] IMM,
    input  logic             IMM_SIGNED,
    input  logic [WIDTH-1:0] PC,
    input  logic [1:0]       SEL_A,
    input  logic [1:0]       SEL_B,
    input  logic             FWD_VALID,
    input  logic [IDX_W-1:0] FWD_RD,
    input  logic [WIDTH-1:0] FWD_DATA,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OP_A,
    output logic [WIDTH-1:0] OP_B
);

    localparam logic [WIDTH-1:0] FOUR_EXT = WIDTH'(CONST_FOUR);

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] reg_a_eff;
    logic [WIDTH-1:0] reg_b_eff;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             load;

    imm_extend #(
        .IMM_W (IMM_W),
        .WIDTH (WIDTH)
    ) u_imm_extend (
        .imm        (IMM),
        .imm_signed (IMM_SIGNED),
        .imm_ext    (imm_ext)
    );

`ifdef ALU_OPERAND_FORWARD_EN
    logic fwd_hit_a;
    logic fwd_hit_b;

    // Register x0 is never a forwarding target; it always reads as REG_x.
    assign fwd_hit_a = FWD_VALID && (FWD_RD == RS_A) && (RS_A != '0);
    assign fwd_hit_b = FWD_VALID && (FWD_RD == RS_B) && (RS_B != '0);
    assign reg_a_eff = fwd_hit_a ? FWD_DATA : REG_A;
    assign reg_b_eff = fwd_hit_b ? FWD_DATA : REG_B;
`else
    // Forwarding disabled: register-file data is used as-is.
    assign reg_a_eff = REG_A;
    assign reg_b_eff = REG_B;
    logic unused_fwd;
    assign unused_fwd = ^{FWD_VALID, FWD_RD, FWD_DATA, RS_A, RS_B};
`endif

    // Operand A mux; reserved encoding falls through to zero.
    always_comb begin
        next_a = '0;
        case (SEL_A)
            SRC_A_REG:  next_a = reg_a_eff;
            SRC_A_PC:   next_a = PC;
            SRC_A_ZERO: next_a = '0;
            default:    next_a = '0;
        endcase
    end

    // Operand B mux; every encoding resolves to a defined value.
    always_comb begin
        next_b = '0;
        case (SEL_B)
            SRC_B_REG:  next_b = reg_b_eff;
            SRC_B_IMM:  next_b = imm_ext;
            SRC_B_FOUR: next_b = FOUR_EXT;
            SRC_B_ZERO: next_b = '0;
            default:    next_b = '0;
        endcase
    end

    assign IN_READY = !OUT_VALID || OUT_READY;
    assign load     = IN_VALID && IN_READY;

    // Pipeline slot: flush beats load, load beats drain, otherwise hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OP_A      <= '0;
            OP_B      <= '0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (load) begin
            OUT_VALID <= 1'b1;
            OP_A      <= next_a;
            OP_B      <= next_b;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule : alu_operand_stage

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands.
REQ-002 Parameter IMM_W, default 16, raw immediate width; SHALL be 1..WIDTH.
REQ-003 Parameter IDX_W, default 5, register index width.
REQ-004 Ports SHALL be exactly:
 CLK  in  1  clock, rising edge;
 RST  in  1  reset, asynchronous, active-high;
 IN_VALID  in  1  upstream operands valid;
 IN_READY  out  1  stage can accept;
 REG_A / REG_B  in  WIDTH  register-file read data;
 RS_A / RS_B  in  IDX_W  source register indices;
 IMM  in  IMM_W  raw immediate;
 IMM_SIGNED  in  1  1 = sign-extend, 0 = zero-extend;
 PC  in  WIDTH  instruction address;
 SEL_A  in  2  0 REG_A, 1 PC, 2 zero, 3 zero;
 SEL_B  in  2  0 REG_B, 1 extended IMM, 2 constant 4, 3 zero;
 FWD_VALID  in  1  forward result valid;
 FWD_RD  in  IDX_W  forward destination index;
 FWD_DATA  in  WIDTH  forward result;
 FLUSH  in  1  discard stage contents;
 OUT_VALID  out  1  operands valid;
 OUT_READY  in  1  downstream accepts;
 OP_A / OP_B  out  WIDTH  registered ALU operands.

Function
REQ-005 Stage SHALL be one registered pipeline slot; latency exactly 1 cycle from accepted input to OUT_VALID.
REQ-006 IN_READY SHALL equal (!OUT_VALID || OUT_READY), combinationally.
REQ-007 Transfer in SHALL occur on a rising CLK edge with IN_VALID && IN_READY; OP_A, OP_B load the selected values and OUT_VALID sets to 1.
REQ-008 With OUT_VALID=1 and OUT_READY=0, OP_A, OP_B, OUT_VALID SHALL hold unchanged.
REQ-009 With OUT_READY=1 and no new input, OUT_VALID SHALL clear next edge; OP_A/OP_B hold last values.
REQ-010 FLUSH=1 SHALL clear OUT_VALID next edge, with priority over any simultaneous load; OP_A/OP_B unchanged.
REQ-011 Immediate extension: IMM_SIGNED=1 replicates IMM[IMM_W-1] into upper bits; 0 fills zeros; IMM_W=WIDTH passes unchanged.
REQ-012 Reserved encodings SEL_A=3 and SEL_B=3 SHALL select zero, never X.
REQ-013 Constant 4 SHALL be zero-extended to WIDTH.

Reset
REQ-014 RST=1 SHALL immediately, independent of CLK, force OUT_VALID=0, OP_A=0, OP_B=0.
REQ-015 On RST deassertion, first transfer SHALL be possible on the next rising edge; an in-flight operand pair is lost.

Configuration
REQ-016 Macro ALU_OPERAND_FORWARD_EN, when defined, SHALL replace the REG_A (REG_B) source with FWD_DATA when FWD_VALID=1, FWD_RD==RS_A (RS_B) and RS_A (RS_B) != 0; forwarding applies only to SEL=0.
REQ-017 Without ALU_OPERAND_FORWARD_EN, FWD_VALID, FWD_RD, FWD_DATA SHALL remain ports but be ignored.

Structure
REQ-018 Select encodings (SRC_A_REG/PC/ZERO, SRC_B_REG/IMM/FOUR/ZERO) and CONST_FOUR SHALL live in shared package cpu_pkg.
REQ-019 Immediate extension SHALL be sub-module imm_extend (parameters IMM_W, WIDTH), combinational.

Verification
REQ-020 Reset: RST=1 mid-stall with OUT_VALID=1 -> OUT_VALID=0, OP_A=OP_B=0 before next edge.
REQ-021 Select: SEL_A=1, PC=0x0000_0100, SEL_B=1, IMM=0xFFFC, IMM_SIGNED=1 -> OP_A=0x0000_0100, OP_B=0xFFFF_FFFC after 1 cycle; IMM_SIGNED=0 -> OP_B=0x0000_FFFC.
REQ-022 Backpressure: load REG_A=0x11, REG_B=0x22, hold OUT_READY=0 three cycles while inputs change -> IN_READY=0, OP_A/OP_B stay 0x11/0x22.
REQ-023 Flush: FLUSH=1 together with a valid input -> OUT_VALID=0 next cycle.
REQ-024 Forwarding (macro defined): RS_A=3, FWD_RD=3, FWD_VALID=1, FWD_DATA=0xDEAD_BEEF, REG_A=0x1 -> OP_A=0xDEAD_BEEF; RS_A=0, FWD_RD=0 -> OP_A=REG_A; macro undefined -> OP_A=0x1.
REQ-025 Reserved: SEL_A=3, SEL_B=3 -> OP_A=OP_B=0.
